// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall controller for the 5-stage pipeline.
// Generates the enables and flushes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// latches from the load-use, memory-wait, redirect, icache-miss and halt conditions.
// Optional build macro PIPE_PERF_EN adds 32-bit cycle/stall/flush counters.
module pipeline_ctrl #(
  parameter int REGW = 5
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_dreq,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            ex_DRen,
  input  logic [REGW-1:0] ex_Rt,
  input  logic            ex_redirect,
  input  logic            mem_halt,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_en,
  output logic            idex_flush,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            halted
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stalls,
  output logic [31:0]     perf_flushes
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DISCARD = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic mstall;
  logic luse;

  // Memory stall freezes everything; load-use needs the loaded register read in ID.
  // Register 0 is hardwired, so it never creates a hazard.
  assign mstall = mem_dreq & ~dhit;
  assign luse   = ex_DRen & (ex_Rt != '0) & ((ex_Rt == id_rs) | (ex_Rt == id_rt));

  // State register; reset abandons any pending discard and returns to RUN.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; all outputs stay 0 while reset is held.
  always_comb begin
    state_next = state;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    halted     = 1'b0;
    if (!nRST) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (mem_halt) begin
            memwb_en   = 1'b1;
            state_next = HALTED;
          end else if (mstall) begin
            state_next = RUN;
          end else if (ex_redirect) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            if (!ihit) begin
              state_next = DISCARD;
            end
          end else if (luse) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (!ihit) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end
        end
        DISCARD: begin
          if (mem_halt) begin
            memwb_en   = 1'b1;
            state_next = HALTED;
          end else if (mstall) begin
            state_next = DISCARD;
          end else begin
            // Wrong-path fetch: bubble IF/ID whether or not the word arrived.
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            if (ihit) begin
              state_next = RUN;
            end
          end
        end
        HALTED: begin
          halted     = 1'b1;
          state_next = HALTED;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  logic flush_event;

  // A flush is a redirect acted on in RUN or an icache word dropped in DISCARD.
  assign flush_event = ~mem_halt & ~mstall &
                       (((state == RUN) & ex_redirect) | ((state == DISCARD) & ihit));

  // Free-running performance counters, wrapping naturally at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_cycles  <= '0;
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else begin
      if (state != HALTED) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if ((state != HALTED) && !pc_en) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
      if (flush_event) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scoreboard bench for pipeline_ctrl.
// Stimulus pushes hand-computed output vectors; a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  localparam int REGW = 5;

  // Output vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted}
  localparam logic [7:0] O_ZERO   = 8'b0000_0000;
  localparam logic [7:0] O_RUN    = 8'b1101_0110;
  localparam logic [7:0] O_REDIR  = 8'b1111_1110;
  localparam logic [7:0] O_LUSE   = 8'b0001_1110;
  localparam logic [7:0] O_MISS   = 8'b0111_0110;
  localparam logic [7:0] O_HALTMW = 8'b0000_0010;
  localparam logic [7:0] O_HALTED = 8'b0000_0001;

  logic            CLK;
  logic            nRST;
  logic            ihit;
  logic            dhit;
  logic            mem_dreq;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            ex_DRen;
  logic [REGW-1:0] ex_Rt;
  logic            ex_redirect;
  logic            mem_halt;
  logic            pc_en;
  logic            ifid_en;
  logic            ifid_flush;
  logic            idex_en;
  logic            idex_flush;
  logic            exmem_en;
  logic            memwb_en;
  logic            halted;
`ifdef PIPE_PERF_EN
  logic [31:0]     perf_cycles;
  logic [31:0]     perf_stalls;
  logic [31:0]     perf_flushes;
`endif

  logic [7:0] obs;
  logic [7:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;

  pipeline_ctrl #(.REGW(REGW)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .mem_dreq    (mem_dreq),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_DRen     (ex_DRen),
    .ex_Rt       (ex_Rt),
    .ex_redirect (ex_redirect),
    .mem_halt    (mem_halt),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_en     (idex_en),
    .idex_flush  (idex_flush),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .halted      (halted)
`ifdef PIPE_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls),
    .perf_flushes(perf_flushes)
`endif
  );

  assign obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted};

  // 10-unit clock period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endfunction

  // Inputs are already set by the caller; record the expectation and advance one cycle.
  task automatic applyStimulus(input logic [7:0] expected, input string name);
    exp_q.push_back(expected);
    name_q.push_back(name);
    @(posedge CLK);
    #1;
  endtask

  task automatic idleInputs();
    ihit        = 1'b1;
    dhit        = 1'b0;
    mem_dreq    = 1'b0;
    id_rs       = '0;
    id_rt       = '0;
    ex_DRen     = 1'b0;
    ex_Rt       = '0;
    ex_redirect = 1'b0;
    mem_halt    = 1'b0;
  endtask

  // Monitor: compare the combinational outputs mid-cycle against the queued expectation.
  always @(negedge CLK) begin
    logic [7:0] e;
    string      n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput(n, {24'd0, obs}, {24'd0, e});
    end
  end

  initial begin
    nRST = 1'b0;
    idleInputs();
    @(posedge CLK);
    #1;

    // Reset state: outputs all zero even with ihit high.
    applyStimulus(O_ZERO, "reset_outputs");
    nRST = 1'b1;
    applyStimulus(O_RUN, "run_idle");

    // Load-use via rs: one bubble, then clears once the load leaves EX.
    ex_DRen = 1'b1; ex_Rt = 5'd5; id_rs = 5'd5; id_rt = 5'd2;
    applyStimulus(O_LUSE, "luse_rs");
    ex_DRen = 1'b0;
    applyStimulus(O_RUN, "luse_cleared");
    // Register 0 never hazards.
    ex_DRen = 1'b1; ex_Rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    applyStimulus(O_RUN, "luse_r0");
    // Load-use via rt.
    ex_Rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
    applyStimulus(O_LUSE, "luse_rt");
    idleInputs();

    // Memory wait freezes a pending redirect, which acts once dhit arrives.
    mem_dreq = 1'b1; dhit = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(O_ZERO, "mstall_freeze");
    dhit = 1'b1;
    applyStimulus(O_REDIR, "mstall_release_redir");
    idleInputs();
    applyStimulus(O_RUN, "redir_ihit_stays_run");

    // Redirect during icache miss goes to DISCARD; the late word is dropped.
    ex_redirect = 1'b1; ihit = 1'b0;
    applyStimulus(O_REDIR, "redir_miss");
    ex_redirect = 1'b0;
    applyStimulus(O_MISS, "discard_wait1");
    mem_dreq = 1'b1;
    applyStimulus(O_ZERO, "discard_mstall");
    mem_dreq = 1'b0;
    applyStimulus(O_MISS, "discard_wait2");
    ihit = 1'b1;
    applyStimulus(O_MISS, "discard_drop");
    applyStimulus(O_RUN, "discard_back_run");

    // Reset mid-DISCARD abandons the discard.
    ex_redirect = 1'b1; ihit = 1'b0;
    applyStimulus(O_REDIR, "redir_miss2");
    ex_redirect = 1'b0;
    nRST = 1'b0;
    applyStimulus(O_ZERO, "reset_in_discard");
    nRST = 1'b1; ihit = 1'b1;
    applyStimulus(O_RUN, "release_run");

    // Halt drains to HALTED and ignores all inputs thereafter.
    mem_halt = 1'b1;
    applyStimulus(O_HALTMW, "halt_memwb");
    mem_halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; dhit = ~i[0]; ex_redirect = i[1]; mem_dreq = i[2];
      ex_DRen = 1'b1; ex_Rt = 5'd4; id_rs = 5'd4;
      applyStimulus(O_HALTED, "halted_sticky");
    end
    idleInputs();
    nRST = 1'b0;
    applyStimulus(O_ZERO, "reset_from_halted");
    nRST = 1'b1;
    applyStimulus(O_RUN, "run_after_halt");

`ifdef PIPE_PERF_EN
    // 20 counted cycles containing one load-use and one redirect with ihit.
    nRST = 1'b0;
    applyStimulus(O_ZERO, "perf_reset");
    nRST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idleInputs();
      if (i == 4) begin
        ex_DRen = 1'b1; ex_Rt = 5'd9; id_rs = 5'd9;
        applyStimulus(O_LUSE, "perf_luse");
      end else if (i == 10) begin
        ex_redirect = 1'b1;
        applyStimulus(O_REDIR, "perf_redir");
      end else begin
        applyStimulus(O_RUN, "perf_idle");
      end
    end
    idleInputs();
    checkOutput("perf_cycles", perf_cycles, 32'd20);
    checkOutput("perf_stalls", perf_stalls, 32'd1);
    checkOutput("perf_flushes", perf_flushes, 32'd1);
`endif

    // Let the monitor drain any remaining expectations, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and stall controller for the 5-stage pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches. Its ID/EX enable output connects to the ID/EX latch's `ieen`.
- Inspects the ID/EX latch outputs (load-in-EX, destination Rt) against the instruction sitting in IF/ID.
- Tracks cache waits, branch/jump redirects and halt drain with a small state machine.

Parameters:
REGW, 5, register-index width (regbits_t).

Ports:
CLK  input  1  pipeline clock
nRST  input  1  asynchronous active-low reset
ihit  input  1  icache returns instruction this cycle
dhit  input  1  dcache completes data access this cycle
mem_dreq  input  1  load/store in MEM stage awaiting dcache
id_rs  input  REGW  rs of instruction in IF/ID
id_rt  input  REGW  rt of instruction in IF/ID
ex_DRen  input  1  DRen_o of ID/EX (load in EX)
ex_Rt  input  REGW  Rt_o of ID/EX
ex_redirect  input  1  branch taken or jump resolved in EX
mem_halt  input  1  halt instruction in MEM stage
pc_en  output  1  PC register load enable
ifid_en  output  1  IF/ID latch enable
ifid_flush  output  1  IF/ID loads bubble
idex_en  output  1  ID/EX latch enable (ieen)
idex_flush  output  1  ID/EX loads bubble
exmem_en  output  1  EX/MEM latch enable
memwb_en  output  1  MEM/WB latch enable
halted  output  1  sticky: pipeline drained on halt

Behaviour:
- Clocking and reset:
  - State register updates on the CLK rising edge.
  - All outputs are combinational from state and inputs.
  - While nRST is low: state = RUN, every output = 0, including halted.
  - Reset mid-operation abandons any pending DISCARD.
- States: RUN, DISCARD, HALTED.
- Derived terms:
  - mstall = mem_dreq & ~dhit.
  - luse = ex_DRen & (ex_Rt != 0) & (ex_Rt == id_rs | ex_Rt == id_rt).
- RUN, priority high to low:
  1. mem_halt: memwb_en=1, all others 0; next state HALTED.
  2. mstall: all enables and flushes 0 (full freeze). A coincident redirect or load-use stays held in the latches and is acted on once dhit arrives.
  3. ex_redirect:
     - pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1.
     - If ~ihit, next state DISCARD; otherwise stay in RUN.
  4. luse: one bubble.
     - pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1.
     - Next cycle the load has left EX, so luse clears naturally. There is no extra stall state.
  5. ~ihit: pc_en=0, ifid_en=1, ifid_flush=1; idex_en, exmem_en, memwb_en=1.
  6. Otherwise: all enables 1, flushes 0.
- DISCARD: the icache is finishing a miss for a wrong-path address.
  - mem_halt and mstall take priority exactly as in RUN.
  - ihit: the returned instruction is dropped. pc_en=0, ifid_en=1, ifid_flush=1, downstream enables 1; next state RUN.
  - ~ihit: same outputs as RUN item 5; stay in DISCARD.
  - A second ex_redirect cannot occur (the ID/EX bubble guarantees it); its outputs are don't-care.
- HALTED:
  - All enables 0, halted=1.
  - Terminal until nRST; all inputs are ignored.
- A register index of 0 never creates a load-use hazard.
- Redirect with ihit=1 in the same cycle: stays in RUN, and the fetched wrong-path word is flushed by ifid_flush.

Optional Feature:
- Macro: PIPE_PERF_EN.
- When defined, adds outputs `perf_cycles`, `perf_stalls`, `perf_flushes` (32 bits each). They are clock-gated by nothing, reset to 0 and wrap modulo 2^32.
  - `perf_cycles` increments on every non-HALTED cycle.
  - `perf_stalls` increments on cycles where pc_en=0 and state != HALTED.
  - `perf_flushes` increments on each ex_redirect acted on in RUN, plus each dropped ihit in DISCARD.
- When undefined: these ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset mid-stream: drive nRST=0 during DISCARD → all outputs 0; after release with ihit=1 → state RUN, all enables=1, flushes=0.
2. Load-use: ex_DRen=1, ex_Rt=5, id_rs=5, ihit=1 → exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; repeat with ex_Rt=0 → no stall.
3. Memory wait: mem_dreq=1, dhit=0 for 3 cycles with ex_redirect=1 → 3 cycles all-zero enables; dhit=1 on cycle 4 → redirect outputs (ifid_flush=idex_flush=pc_en=1) in that cycle.
4. Redirect during icache miss: ex_redirect=1, ihit=0 → flushes asserted, state DISCARD; ihit=0 ×2 then ihit=1 → that cycle ifid_flush=1, pc_en=0; next cycle with ihit=1 → pc_en=1, ifid_flush=0.
5. Halt: mem_halt=1 → memwb_en=1 only, next cycle halted=1 and all enables 0; stays halted with ihit/dhit toggling for 10 cycles.
6. PIPE_PERF_EN: 20 cycles containing 1 load-use and 1 redirect with ihit=1 → perf_cycles=20, perf_stalls=1, perf_flushes=1.
